// File: rtl/tile_sched_pkg.sv
// Shared definitions for the tiled matmul scheduler: opcodes, FSM states and the
// tile address helper used to build addr_1 for FILL, CALC and STORE.
package tile_sched_pkg;

    localparam logic [2:0] OP_CLEAR      = 3'd1;
    localparam logic [2:0] OP_FILL       = 3'd2;
    localparam logic [2:0] OP_DRAIN      = 3'd3;
    localparam logic [2:0] OP_CALC       = 3'd4;
    localparam logic [2:0] OP_STORE      = 3'd5;
    localparam logic [2:0] OP_STORE_RELU = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } sched_state_e;

    // Callers truncate the result to their address width, which gives the wrap.
    function automatic logic [31:0] tile_addr(input logic [31:0] base,
                                              input logic [31:0] index,
                                              input logic [31:0] wh);
        return base + index * wh;
    endfunction

endpackage

// File: rtl/tile_loop_counter.sv
// Nested mt/nt/kt tile counter. Exposes next-cycle values so the scheduler can
// register a command's fields on the same edge that the counters move.
module tile_loop_counter #(
    parameter int TILE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance_k,
    input  logic              advance_mn,
    input  logic [TILE_W-1:0] m_lim,
    input  logic [TILE_W-1:0] n_lim,
    input  logic [TILE_W-1:0] k_lim,
    output logic [TILE_W-1:0] mt_nxt,
    output logic [TILE_W-1:0] nt_nxt,
    output logic [TILE_W-1:0] kt_nxt,
    output logic              last_k,
    output logic              last_job
);

    logic [TILE_W-1:0] mt_q, nt_q, kt_q;
    logic [TILE_W-1:0] mt_d, nt_d, kt_d;

    always_comb begin
        mt_d = mt_q;
        nt_d = nt_q;
        kt_d = kt_q;
        if (clear) begin
            mt_d = '0;
            nt_d = '0;
            kt_d = '0;
        end else if (advance_mn) begin
            kt_d = '0;
            if (nt_q == n_lim) begin
                nt_d = '0;
                mt_d = mt_q + 1'b1;
            end else begin
                nt_d = nt_q + 1'b1;
            end
        end else if (advance_k) begin
            kt_d = kt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_q <= '0;
            nt_q <= '0;
            kt_q <= '0;
        end else begin
            mt_q <= mt_d;
            nt_q <= nt_d;
            kt_q <= kt_d;
        end
    end

    assign mt_nxt   = mt_d;
    assign nt_nxt   = nt_d;
    assign kt_nxt   = kt_d;
    assign last_k   = (kt_q == k_lim);
    assign last_job = (mt_q == m_lim) && (nt_q == n_lim);

endmodule

// File: rtl/tile_scheduler.sv
// Issues one tiled matmul job to master_control as CLEAR/FILL/DRAIN/CALC/STORE ops.
// Define TILE_SCHED_WATCHDOG_EN to bound each WAIT by TIMEOUT cycles.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int WIDTH_HEIGHT = 16,
    parameter int MAX_MAT_WH   = 128,
    parameter int ADDR_WIDTH   = 8,
    parameter int TILE_W       = $clog2(MAX_MAT_WH / WIDTH_HEIGHT),
    parameter int TIMEOUT      = 1024
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [TILE_W-1:0]     cmd_m_tiles,
    input  logic [TILE_W-1:0]     cmd_n_tiles,
    input  logic [TILE_W-1:0]     cmd_k_tiles,
    input  logic [ADDR_WIDTH-1:0] cmd_w_base,
    input  logic [ADDR_WIDTH-1:0] cmd_in_base,
    input  logic [ADDR_WIDTH-1:0] cmd_out_base,
    input  logic                  cmd_relu,
    input  logic                  abort,
    output logic                  mc_start,
    output logic [2:0]            mc_opcode,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [TILE_W-1:0]     mc_submat_row,
    output logic [TILE_W-1:0]     mc_submat_col,
    input  logic                  mc_done,
    output logic                  busy,
    output logic                  job_done,
    output logic                  job_err
);

    sched_state_e          state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [TILE_W-1:0]     m_lim_q, m_lim_d, n_lim_q, n_lim_d, k_lim_q, k_lim_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d, in_base_q, in_base_d, out_base_q, out_base_d;
    logic                  relu_q, relu_d;
    logic                  cmd_ready_q, cmd_ready_d, mc_start_q, mc_start_d;
    logic [2:0]            mc_opcode_q, mc_opcode_d;
    logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d, addr_sel;
    logic [TILE_W-1:0]     row_q, row_d, col_q, col_d;
    logic                  busy_q, busy_d, job_done_q, job_done_d, job_err_q, job_err_d;
    logic                  ctr_clear, adv_k, adv_mn, last_k, last_job, fin_err, wd_expired;
    logic [TILE_W-1:0]     mt_nxt, nt_nxt, kt_nxt;

    tile_loop_counter #(.TILE_W(TILE_W)) u_loop (
        .clk       (axi_clk),
        .rst_n     (axi_reset),
        .clear     (ctr_clear),
        .advance_k (adv_k),
        .advance_mn(adv_mn),
        .m_lim     (m_lim_q),
        .n_lim     (n_lim_q),
        .k_lim     (k_lim_q),
        .mt_nxt    (mt_nxt),
        .nt_nxt    (nt_nxt),
        .kt_nxt    (kt_nxt),
        .last_k    (last_k),
        .last_job  (last_job)
    );

`ifdef TILE_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == S_ISSUE)     wd_d = '0;
        else if (state_q == S_WAIT) wd_d = wd_q + 1'b1;
    end

    // The ISSUE cycle is the first of the TIMEOUT cycles, so FINISH lands TIMEOUT after start.
    assign wd_expired = (state_q == S_WAIT) && (wd_q == WD_W'(TIMEOUT - 2));

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) wd_q <= '0;
        else            wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign wd_expired     = 1'b0;
`endif

    // Fields are computed from next-cycle counters and latched values so they are valid in ISSUE.
    always_comb begin
        case (op_d)
            OP_FILL:  addr_sel = ADDR_WIDTH'(tile_addr(32'(w_base_d),
                          32'(kt_nxt) * (32'(n_lim_d) + 32'd1) + 32'(nt_nxt), 32'(WIDTH_HEIGHT)));
            OP_CALC:  addr_sel = ADDR_WIDTH'(tile_addr(32'(in_base_d),
                          32'(mt_nxt) * (32'(k_lim_d) + 32'd1) + 32'(kt_nxt), 32'(WIDTH_HEIGHT)));
            OP_STORE: addr_sel = ADDR_WIDTH'(tile_addr(32'(out_base_d),
                          32'(mt_nxt) * (32'(n_lim_d) + 32'd1) + 32'(nt_nxt), 32'(WIDTH_HEIGHT)));
            default:  addr_sel = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;     op_d = op_q;
        m_lim_d = m_lim_q;     n_lim_d = n_lim_q;       k_lim_d = k_lim_q;
        w_base_d = w_base_q;   in_base_d = in_base_q;   out_base_d = out_base_q;
        relu_d = relu_q;
        ctr_clear = 1'b0;      adv_k = 1'b0;            adv_mn = 1'b0;
        fin_err = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready_q) begin
                m_lim_d = cmd_m_tiles;   n_lim_d = cmd_n_tiles;     k_lim_d = cmd_k_tiles;
                w_base_d = cmd_w_base;   in_base_d = cmd_in_base;   out_base_d = cmd_out_base;
                relu_d = cmd_relu;
                ctr_clear = 1'b1;
                op_d = OP_CLEAR;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mc_done) state_d = S_ADVANCE;
                else if (wd_expired) begin
                    state_d = S_FINISH;
                    fin_err = 1'b1;
                end
            end
            S_ADVANCE: begin
                state_d = S_ISSUE;
                if (abort) begin
                    state_d = S_FINISH;
                    fin_err = 1'b1;
                end else begin
                    case (op_q)
                        OP_CLEAR: op_d = OP_FILL;
                        OP_FILL:  op_d = OP_DRAIN;
                        OP_DRAIN: op_d = OP_CALC;
                        OP_CALC: begin
                            op_d  = last_k ? OP_STORE : OP_FILL;
                            adv_k = !last_k;
                        end
                        default: begin
                            if (last_job) state_d = S_FINISH;
                            else begin
                                op_d   = OP_CLEAR;
                                adv_mn = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        mc_start_d  = (state_d == S_ISSUE);
        busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_ADVANCE);
        job_done_d  = (state_d == S_FINISH);
        job_err_d   = (state_d == S_FINISH) && fin_err;
        mc_opcode_d = mc_opcode_q;  mc_addr_d = mc_addr_q;
        row_d = row_q;              col_d = col_q;
        if (state_d == S_ISSUE) begin
            mc_opcode_d = (op_d == OP_STORE && relu_d) ? OP_STORE_RELU : op_d;
            mc_addr_d   = addr_sel;
            row_d       = mt_nxt;
            col_d       = nt_nxt;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            state_q <= S_IDLE;    op_q <= '0;
            m_lim_q <= '0;        n_lim_q <= '0;        k_lim_q <= '0;
            w_base_q <= '0;       in_base_q <= '0;      out_base_q <= '0;
            relu_q <= 1'b0;       cmd_ready_q <= 1'b1;  mc_start_q <= 1'b0;
            mc_opcode_q <= '0;    mc_addr_q <= '0;      row_q <= '0;  col_q <= '0;
            busy_q <= 1'b0;       job_done_q <= 1'b0;   job_err_q <= 1'b0;
        end else begin
            state_q <= state_d;   op_q <= op_d;
            m_lim_q <= m_lim_d;   n_lim_q <= n_lim_d;   k_lim_q <= k_lim_d;
            w_base_q <= w_base_d; in_base_q <= in_base_d; out_base_q <= out_base_d;
            relu_q <= relu_d;     cmd_ready_q <= cmd_ready_d; mc_start_q <= mc_start_d;
            mc_opcode_q <= mc_opcode_d; mc_addr_q <= mc_addr_d; row_q <= row_d; col_q <= col_d;
            busy_q <= busy_d;     job_done_q <= job_done_d; job_err_q <= job_err_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign mc_start      = mc_start_q;
    assign mc_opcode     = mc_opcode_q;
    assign mc_addr       = mc_addr_q;
    assign mc_submat_row = row_q;
    assign mc_submat_col = col_q;
    assign busy          = busy_q;
    assign job_done      = job_done_q;
    assign job_err       = job_err_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: expected commands and job endings are queued
// by the drivers and checked by a monitor whenever the DUT starts an op or ends a job.
module tb_tile_scheduler;

    logic       axi_clk, axi_reset;
    logic       cmd_valid, cmd_ready, cmd_relu, abort;
    logic [2:0] cmd_m_tiles, cmd_n_tiles, cmd_k_tiles;
    logic [7:0] cmd_w_base, cmd_in_base, cmd_out_base;
    logic       mc_start, mc_done, busy, job_done, job_err;
    logic [2:0] mc_opcode, mc_submat_row, mc_submat_col;
    logic [7:0] mc_addr;

    tile_scheduler #(.TIMEOUT(16)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m_tiles(cmd_m_tiles), .cmd_n_tiles(cmd_n_tiles), .cmd_k_tiles(cmd_k_tiles),
        .cmd_w_base(cmd_w_base), .cmd_in_base(cmd_in_base), .cmd_out_base(cmd_out_base),
        .cmd_relu(cmd_relu), .abort(abort),
        .mc_start(mc_start), .mc_opcode(mc_opcode), .mc_addr(mc_addr),
        .mc_submat_row(mc_submat_row), .mc_submat_col(mc_submat_col),
        .mc_done(mc_done), .busy(busy), .job_done(job_done), .job_err(job_err)
    );

    // ---------------- clock / reset ----------------
    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];        // {opcode, addr, row, col}
    logic        exp_done_q[$];   // expected job_err at job_done
    int n_checks = 0, n_fail = 0;
    int n_starts = 0, last_start_cyc = 0, done_cyc = 0;
    bit done_seen = 0, resp_en = 1;
    logic [16:0] last_cmd = '0;
    int model_cnt = 0, model_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [21:0] out_pack();
        return {cmd_ready, mc_start, mc_opcode, mc_addr, mc_submat_row, mc_submat_col,
                busy, job_done, job_err};
    endfunction

    localparam logic [21:0] RESET_PACK = {1'b1, 21'd0};

    // ---------------- master_control responder: done 3 cycles after start ----------------
    initial begin
        mc_done = 1'b0;
        forever begin
            @(negedge axi_clk);
            if (mc_start === 1'b1 && resp_en) begin
                repeat (3) @(negedge axi_clk);
                if (resp_en && axi_reset) begin
                    mc_done   = 1'b1;
                    done_seen = 1'b1;
                    done_cyc  = cyc;
                    @(negedge axi_clk);
                    mc_done = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge axi_clk) begin
        if (axi_reset === 1'b1) begin
            if (mc_start === 1'b1) begin
                n_starts++;
                last_start_cyc = cyc;
                last_cmd = {mc_opcode, mc_addr, mc_submat_row, mc_submat_col};
                if (done_seen) check("done_to_start_gap", cyc - done_cyc, 2);
                done_seen = 1'b0;
                if (exp_q.size() == 0) fail_now("unexpected_mc_start");
                else check("mc_cmd", {15'd0, last_cmd}, {15'd0, exp_q.pop_front()});
            end
            if (job_done === 1'b1 || job_err === 1'b1) begin
                if (exp_done_q.size() == 0) fail_now("unexpected_job_done");
                else check("job_done_err_busy", {job_done, job_err, busy},
                           {1'b1, exp_done_q.pop_front(), 1'b0});
                if (done_seen) check("done_to_job_done_gap", cyc - done_cyc, 2);
                done_seen = 1'b0;
            end
        end
    end

    // ---------------- model / drivers ----------------
    task automatic add_op(input logic [2:0] op, input logic [7:0] a, input int mt, input int nt);
        if (model_cnt < model_max) exp_q.push_back({op, a, 3'(mt), 3'(nt)});
        model_cnt++;
    endtask

    task automatic model_job(input int m, input int n, input int k,
                             input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                             input bit relu, input int max_ops, input bit with_done, input bit err);
        model_cnt = 0;
        model_max = max_ops;
        for (int mt = 0; mt <= m; mt++) begin
            for (int nt = 0; nt <= n; nt++) begin
                add_op(3'd1, 8'h00, mt, nt);
                for (int kt = 0; kt <= k; kt++) begin
                    add_op(3'd2, 8'(int'(wb) + (kt * (n + 1) + nt) * 16), mt, nt);
                    add_op(3'd3, 8'h00, mt, nt);
                    add_op(3'd4, 8'(int'(ib) + (mt * (k + 1) + kt) * 16), mt, nt);
                end
                add_op(relu ? 3'd6 : 3'd5, 8'(int'(ob) + (mt * (n + 1) + nt) * 16), mt, nt);
            end
        end
        if (with_done) exp_done_q.push_back(err);
    endtask

    task automatic set_cmd(input int m, input int n, input int k,
                           input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                           input logic relu);
        cmd_m_tiles = 3'(m);  cmd_n_tiles = 3'(n);  cmd_k_tiles = 3'(k);
        cmd_w_base = wb;      cmd_in_base = ib;     cmd_out_base = ob;
        cmd_relu = relu;      cmd_valid = 1'b1;
    endtask

    task automatic send_cmd(input int m, input int n, input int k,
                            input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                            input logic relu);
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 200) begin
            @(negedge axi_clk);
            t++;
        end
        if (cmd_ready !== 1'b1) fail_now("cmd_ready_timeout");
        set_cmd(m, n, k, wb, ib, ob, relu);
        @(negedge axi_clk);
        cmd_valid = 1'b0;
        check("busy_ready_after_accept", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic wait_job_done(output int at);
        int t = 0;
        do begin
            @(negedge axi_clk);
            t++;
        end while (job_done !== 1'b1 && t < 3000);
        if (job_done !== 1'b1) fail_now("job_done_timeout");
        at = cyc;
    endtask

    task automatic wait_starts(input int n);
        int t = 0;
        while (n_starts < n && t < 500) begin
            @(negedge axi_clk);
            t++;
        end
        if (n_starts < n) fail_now("start_count_timeout");
    endtask

    // ---------------- directed sequence ----------------
    int at;
    initial begin
        axi_reset = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        set_cmd(0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        cmd_valid = 1'b0;
        repeat (2) @(negedge axi_clk);
        check("reset_values", {10'd0, out_pack()}, {10'd0, RESET_PACK});
        axi_reset = 1'b1;
        @(negedge axi_clk);
        check("idle_after_reset", {10'd0, out_pack()}, {10'd0, RESET_PACK});

        // single tile, then a second job presented during FINISH (K=7, wrapping FILL addresses)
        n_starts = 0;
        exp_q.push_back({3'd1, 8'h00, 3'd0, 3'd0});
        exp_q.push_back({3'd2, 8'h10, 3'd0, 3'd0});
        exp_q.push_back({3'd3, 8'h00, 3'd0, 3'd0});
        exp_q.push_back({3'd4, 8'h20, 3'd0, 3'd0});
        exp_q.push_back({3'd5, 8'h40, 3'd0, 3'd0});
        exp_done_q.push_back(1'b0);
        model_job(0, 0, 7, 8'hF0, 8'h80, 8'h33, 1'b0, 1000, 1'b1, 1'b0);
        send_cmd(0, 0, 0, 8'h10, 8'h20, 8'h40, 1'b0);
        wait_job_done(at);
        check("single_tile_starts", n_starts, 5);
        n_starts = 0;
        set_cmd(0, 0, 7, 8'hF0, 8'h80, 8'h33, 1'b0);
        @(negedge axi_clk);
        check("no_accept_in_finish", {busy, cmd_ready}, 2'b01);
        @(negedge axi_clk);
        cmd_valid = 1'b0;
        check("accept_in_idle", {busy, cmd_ready}, 2'b10);
        wait_job_done(at);
        check("wrap_job_starts", n_starts, 26);
        check("wrap_job_last_cmd", {15'd0, last_cmd}, {15'd0, 3'd5, 8'h33, 3'd0, 3'd0});

        // 2x2x2 with ReLU
        n_starts = 0;
        model_job(1, 1, 1, 8'h00, 8'h00, 8'h00, 1'b1, 1000, 1'b1, 1'b0);
        send_cmd(1, 1, 1, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_job_done(at);
        check("relu_job_starts", n_starts, 32);
        check("relu_job_last_cmd", {15'd0, last_cmd}, {15'd0, 3'd6, 8'd48, 3'd1, 3'd1});

        // abort during WAIT of the third op
        n_starts = 0;
        model_job(1, 1, 1, 8'h00, 8'h00, 8'h00, 1'b0, 3, 1'b1, 1'b1);
        send_cmd(1, 1, 1, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_starts(3);
        @(negedge axi_clk);
        abort = 1'b1;
        wait_job_done(at);
        abort = 1'b0;
        @(negedge axi_clk);
        check("abort_back_to_idle", {busy, cmd_ready}, 2'b01);
        repeat (4) @(negedge axi_clk);
        check("abort_start_count", n_starts, 3);

        // reset in the middle of WAIT, then a fresh job
        n_starts = 0;
        model_job(0, 0, 0, 8'h10, 8'h20, 8'h40, 1'b0, 2, 1'b0, 1'b0);
        send_cmd(0, 0, 0, 8'h10, 8'h20, 8'h40, 1'b0);
        wait_starts(2);
        @(negedge axi_clk);
        #1 axi_reset = 1'b0;
        #1 check("async_reset_values", {10'd0, out_pack()}, {10'd0, RESET_PACK});
        done_seen = 1'b0;
        repeat (3) @(negedge axi_clk);
        axi_reset = 1'b1;
        check("reset_left_pending", exp_q.size() + exp_done_q.size(), 0);
        n_starts = 0;
        exp_q.push_back({3'd1, 8'h00, 3'd0, 3'd0});
        exp_q.push_back({3'd2, 8'h30, 3'd0, 3'd0});
        exp_q.push_back({3'd3, 8'h00, 3'd0, 3'd0});
        exp_q.push_back({3'd4, 8'h50, 3'd0, 3'd0});
        exp_q.push_back({3'd6, 8'h70, 3'd0, 3'd0});
        exp_done_q.push_back(1'b0);
        send_cmd(0, 0, 0, 8'h30, 8'h50, 8'h70, 1'b1);
        wait_job_done(at);
        check("post_reset_job_starts", n_starts, 5);

        // stray mc_done while idle
        repeat (2) @(negedge axi_clk);
        n_starts = 0;
        mc_done = 1'b1;
        @(negedge axi_clk);
        mc_done = 1'b0;
        repeat (3) @(negedge axi_clk);
        check("idle_done_ignored", {29'd0, busy, cmd_ready, mc_start}, {29'd0, 3'b010});
        check("idle_done_no_start", n_starts, 0);

`ifdef TILE_SCHED_WATCHDOG_EN
        resp_en = 1'b0;
        n_starts = 0;
        exp_q.push_back({3'd1, 8'h00, 3'd0, 3'd0});
        exp_done_q.push_back(1'b1);
        send_cmd(0, 0, 0, 8'h10, 8'h20, 8'h40, 1'b0);
        wait_job_done(at);
        check("watchdog_latency", at - last_start_cyc, 16);
        resp_en = 1'b1;
`endif

        repeat (3) @(negedge axi_clk);
        check("scoreboard_drained", exp_q.size() + exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit (t=%0t)", $time);
        $fatal(1, "time limit");
    end

endmodule
